// File: rtl/rv_ifu_fetch_pkg.sv
// Shared definitions for the RV32 instruction-fetch stage and its consumers.
package rv_ifu_fetch_pkg;

    localparam int unsigned XLEN = 32;

    // Width of the {pc, inst} message handed from fetch to decode.
    localparam int unsigned IF_ID_WIDTH = 2 * XLEN;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/rv_ifu_fetch.sv
// Instruction-fetch stage: holds the PC, issues one word fetch at a time and
// presents {pc, inst} to decode. Redirects override the PC in every state and
// cause any in-flight fetch made stale by them to be dropped.
module rv_ifu_fetch
    import rv_ifu_fetch_pkg::*;
#(
    parameter int unsigned       WIDTH    = XLEN,
    parameter logic [WIDTH-1:0]  RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [WIDTH-1:0]     imem_addr,
    input  logic                 imem_rsp_valid,
    input  logic [WIDTH-1:0]     imem_rsp_data,
    output logic                 imem_rsp_ready,
    input  logic                 redirect_valid,
    input  logic [WIDTH-1:0]     redirect_pc,
    output logic                 if_id_valid,
    input  logic                 if_id_ready,
    output logic [2*WIDTH-1:0]   IF_ID_message,
    output logic                 if_misalign
);

    fetch_state_t          r_state;
    logic [WIDTH-1:0]      r_pc;
    logic [WIDTH-1:0]      r_addr;
    logic                  r_stale;
    logic [2*WIDTH-1:0]    r_out;
    logic                  r_misalign;

    logic [WIDTH-1:0]      w_redir_tgt;
    logic [WIDTH-1:0]      w_pc_next;
    logic                  w_redir_mis;

    // Redirect targets are word-aligned by dropping the low two bits.
    assign w_redir_tgt = {redirect_pc[WIDTH-1:2], 2'b00};
    assign w_redir_mis = |redirect_pc[1:0];
    assign w_pc_next   = r_pc + WIDTH'(4);

    assign imem_req_valid = (r_state == S_REQ);
    assign imem_addr      = r_addr;
    assign imem_rsp_ready = (r_state == S_WAIT);
    assign if_id_valid    = (r_state == S_HOLD);
    assign IF_ID_message  = r_out;
    assign if_misalign    = r_misalign;

    // Fetch FSM: request, wait for response, hold result until decode takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_stale <= 1'b0;
            r_out   <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    // The issued request is left untouched; its response is
                    // marked for discard and the target refetched afterwards.
                    if (redirect_valid) begin
                        r_pc    <= w_redir_tgt;
                        r_stale <= 1'b1;
                    end
                    if (imem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        r_pc <= w_redir_tgt;
                        if (imem_rsp_valid) begin
                            // Response retires this cycle, so nothing is left
                            // in flight to mark stale: fetch the target next.
                            r_addr  <= w_redir_tgt;
                            r_stale <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_stale <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (r_stale) begin
                            r_addr  <= r_pc;
                            r_stale <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_out   <= {r_addr, imem_rsp_data};
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        r_pc    <= w_redir_tgt;
                        r_addr  <= w_redir_tgt;
                        r_out   <= '0;
                        r_state <= S_REQ;
                    end else if (if_id_ready) begin
                        r_pc    <= w_pc_next;
                        r_addr  <= w_pc_next;
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

    // Sticky record of any redirect whose target was not word aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misalign <= 1'b0;
        end else if (redirect_valid && w_redir_mis) begin
            r_misalign <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rv_ifu_fetch.sv
// Self-checking bench for rv_ifu_fetch: directed vector table, a mid-transaction
// reset sequence, then randomized traffic against a transaction-level model.
module tb_rv_ifu_fetch;
    import rv_ifu_fetch_pkg::*;

    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam int ER = 0;
    localparam int EW = 1;
    localparam int EH = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [31:0]            imem_addr;
    logic                   imem_rsp_valid;
    logic [31:0]            imem_rsp_data;
    logic                   imem_rsp_ready;
    logic                   redirect_valid;
    logic [31:0]            redirect_pc;
    logic                   if_id_valid;
    logic                   if_id_ready;
    logic [IF_ID_WIDTH-1:0] IF_ID_message;
    logic                   if_misalign;

    int checks = 0;
    int errors = 0;

    rv_ifu_fetch #(.WIDTH(32), .RESET_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_ready (imem_rsp_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_ready    (if_id_ready),
        .IF_ID_message  (IF_ID_message),
        .if_misalign    (if_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rr;
        logic        rv;
        logic [31:0] rd;
        logic        xv;
        logic [31:0] xpc;
        logic        ir;
        int          e_st;
        logic [31:0] e_addr;
        logic [63:0] e_msg;
        logic        e_mis;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rr, input logic rv, input logic [31:0] rd,
                                input logic xv, input logic [31:0] xpc, input logic ir,
                                input int e_st, input logic [31:0] e_addr,
                                input logic [63:0] e_msg, input logic e_mis);
        vec_t v;
        v.rr = rr; v.rv = rv; v.rd = rd; v.xv = xv; v.xpc = xpc; v.ir = ir;
        v.e_st = e_st; v.e_addr = e_addr; v.e_msg = e_msg; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_id_ready    = 1'b0;
    endtask

    // random-phase model state
    logic        mem_out;
    logic [31:0] mem_addr;
    int          mem_cnt;
    logic [31:0] exp_pc;
    logic        exp_mis;
    logic        prev_req_stall, prev_id_stall;
    logic [31:0] prev_addr;
    logic [63:0] prev_msg;
    logic        f_req, f_rsp, f_id;
    logic [31:0] xpc;
    int          emitted, idle;

    initial begin
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 64'(imem_req_valid), 64'd1);
        chk("rst_addr", 64'(imem_addr), 64'(RPC));
        chk("rst_id_valid", 64'(if_id_valid), 64'd0);
        chk("rst_rsp_ready", 64'(imem_rsp_ready), 64'd0);
        chk("rst_misalign", 64'(if_misalign), 64'd0);
        rst = 1'b1;

        //              rr rv rd            xv xpc           ir st  addr          msg                          mis
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, EW, 32'h80000000, 64'h0,                       0));
        tbl.push_back(mk(0, 1, 32'h00000013, 0, 32'h0,        0, EH, 32'h80000000, 64'h80000000_00000013,       0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 32'h0,    0, 32'h0,        0, EH, 32'h80000000, 64'h80000000_00000013,       0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, ER, 32'h80000004, 64'h0,                       0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, ER, 32'h80000004, 64'h0,                       0));
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, EW, 32'h80000004, 64'h0,                       0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h80000100, 0, EW, 32'h80000004, 64'h0,                       0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, EW, 32'h80000004, 64'h0,                       0));
        tbl.push_back(mk(0, 1, 32'hDEADBEEF, 0, 32'h0,        0, ER, 32'h80000100, 64'h0,                       0));
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, EW, 32'h80000100, 64'h0,                       0));
        tbl.push_back(mk(0, 1, 32'h00100093, 0, 32'h0,        0, EH, 32'h80000100, 64'h80000100_00100093,       0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, ER, 32'h80000104, 64'h0,                       0));
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, EW, 32'h80000104, 64'h0,                       0));
        tbl.push_back(mk(0, 1, 32'h11111111, 1, 32'h80000200, 0, ER, 32'h80000200, 64'h0,                       0));
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, EW, 32'h80000200, 64'h0,                       0));
        tbl.push_back(mk(0, 1, 32'h22222222, 0, 32'h0,        0, EH, 32'h80000200, 64'h80000200_22222222,       0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h80000302, 1, ER, 32'h80000300, 64'h0,                       1));
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, EW, 32'h80000300, 64'h0,                       1));
        tbl.push_back(mk(0, 1, 32'h33333333, 0, 32'h0,        0, EH, 32'h80000300, 64'h80000300_33333333,       1));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, ER, 32'h80000304, 64'h0,                       1));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, ER, 32'h80000304, 64'h0,                       1));
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, EW, 32'h80000304, 64'h0,                       1));
        tbl.push_back(mk(0, 1, 32'h44444444, 0, 32'h0,        0, ER, 32'hFFFFFFFC, 64'h0,                       1));
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, EW, 32'hFFFFFFFC, 64'h0,                       1));
        tbl.push_back(mk(0, 1, 32'h55555555, 0, 32'h0,        0, EH, 32'hFFFFFFFC, 64'hFFFFFFFC_55555555,       1));
        tbl.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, ER, 32'h00000000, 64'h0,                       1));
        tbl.push_back(mk(1, 0, 32'h0,        1, 32'h00000040, 0, EW, 32'h00000000, 64'h0,                       1));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h00000080, 0, EW, 32'h00000000, 64'h0,                       1));
        tbl.push_back(mk(0, 1, 32'h00000006, 0, 32'h0,        0, ER, 32'h00000080, 64'h0,                       1));
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, EW, 32'h00000080, 64'h0,                       1));
        tbl.push_back(mk(0, 1, 32'h00000077, 0, 32'h0,        0, EH, 32'h00000080, 64'h00000080_00000077,       1));
        tbl.push_back(mk(0, 0, 32'h0,        1, 32'h00000010, 0, ER, 32'h00000010, 64'h0,                       1));
        tbl.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, EW, 32'h00000010, 64'h0,                       1));

        for (int i = 0; i < tbl.size(); i++) begin
            imem_req_ready = tbl[i].rr;
            imem_rsp_valid = tbl[i].rv;
            imem_rsp_data  = tbl[i].rd;
            redirect_valid = tbl[i].xv;
            redirect_pc    = tbl[i].xpc;
            if_id_ready    = tbl[i].ir;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_req_valid", i), 64'(imem_req_valid), 64'(tbl[i].e_st == ER));
            chk($sformatf("v%0d_rsp_ready", i), 64'(imem_rsp_ready), 64'(tbl[i].e_st == EW));
            chk($sformatf("v%0d_id_valid", i), 64'(if_id_valid), 64'(tbl[i].e_st == EH));
            chk($sformatf("v%0d_addr", i), 64'(imem_addr), 64'(tbl[i].e_addr));
            chk($sformatf("v%0d_misalign", i), 64'(if_misalign), 64'(tbl[i].e_mis));
            if (tbl[i].e_st == EH)
                chk($sformatf("v%0d_msg", i), IF_ID_message, tbl[i].e_msg);
        end

        // Reset pulsed mid-cycle while a fetch is outstanding in WAIT.
        idle_inputs();
        #2 rst = 1'b0;
        #1;
        chk("midrst_id_valid", 64'(if_id_valid), 64'd0);
        chk("midrst_req_valid", 64'(imem_req_valid), 64'd1);
        chk("midrst_addr", 64'(imem_addr), 64'(RPC));
        chk("midrst_misalign", 64'(if_misalign), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        chk("postrst_addr", 64'(imem_addr), 64'(RPC));
        chk("postrst_rsp_ready", 64'(imem_rsp_ready), 64'd0);

        // Randomized traffic against a transaction-level model.
        mem_out = 1'b0; mem_addr = '0; mem_cnt = 0;
        exp_pc = RPC; exp_mis = 1'b0;
        prev_req_stall = 1'b0; prev_id_stall = 1'b0;
        prev_addr = '0; prev_msg = '0;
        emitted = 0; idle = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            imem_req_ready = ($urandom_range(0, 9) < 7);
            if_id_ready    = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 99) < 6);
            xpc = 32'h8000_0000 | ($urandom & 32'h0000_0FFC);
            if ($urandom_range(0, 3) == 0) xpc[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) xpc = 32'hFFFF_FFF0 | (xpc & 32'hF);
            redirect_pc    = xpc;
            imem_rsp_valid = mem_out && (mem_cnt == 0);
            imem_rsp_data  = imem_rsp_valid ? mem_fn(mem_addr) : $urandom;

            chk("rnd_misalign", 64'(if_misalign), 64'(exp_mis));
            if (prev_req_stall) begin
                chk("rnd_req_hold_valid", 64'(imem_req_valid), 64'd1);
                chk("rnd_req_hold_addr", 64'(imem_addr), 64'(prev_addr));
            end
            if (prev_id_stall) begin
                chk("rnd_id_hold_valid", 64'(if_id_valid), 64'd1);
                chk("rnd_id_hold_msg", IF_ID_message, prev_msg);
            end
            if (imem_req_valid) begin
                chk("rnd_one_outstanding", 64'(mem_out), 64'd0);
                chk("rnd_addr_align", 64'(imem_addr[1:0]), 64'd0);
            end

            f_req = imem_req_valid && imem_req_ready;
            f_rsp = imem_rsp_valid && imem_rsp_ready;
            f_id  = if_id_valid && if_id_ready && !redirect_valid;

            if (f_id) begin
                chk("rnd_emit_pc", 64'(IF_ID_message[63:32]), 64'(exp_pc));
                chk("rnd_emit_inst", 64'(IF_ID_message[31:0]), 64'(mem_fn(exp_pc)));
                exp_pc = exp_pc + 32'd4;
                emitted++;
                idle = 0;
            end else begin
                idle++;
            end
            if (redirect_valid) begin
                exp_pc = {xpc[31:2], 2'b00};
                if (xpc[1:0] != 2'b00) exp_mis = 1'b1;
            end

            prev_req_stall = imem_req_valid && !imem_req_ready;
            prev_addr      = imem_addr;
            prev_id_stall  = if_id_valid && !if_id_ready && !redirect_valid;
            prev_msg       = IF_ID_message;

            @(posedge clk);
            #1;
            if (f_rsp) mem_out = 1'b0;
            if (f_req) begin
                mem_out  = 1'b1;
                mem_addr = prev_addr;
                mem_cnt  = $urandom_range(0, 3);
            end else if (mem_out && mem_cnt > 0) begin
                mem_cnt--;
            end
            if (idle > 300) begin
                chk("rnd_liveness_idle", 64'(idle), 64'd0);
                break;
            end
        end
        chk("rnd_progress", 64'(emitted >= 100), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_ifu_fetch.md
Name: rv_ifu_fetch

Overview:
- Instruction-fetch stage of the RV32 core. Sits directly upstream of the decode stage.
- Holds the PC and issues one word fetch at a time to the instruction memory over a valid/ready request/response bus.
- Presents {pc, inst} to decode through a registered valid/ready output.
- Accepts PC redirects from branch/jump resolution and discards any in-flight fetch made stale by a redirect.

Parameters:
- WIDTH, 32, datapath and address width.
- RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  WIDTH  fetch address; word aligned.
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  WIDTH  fetched instruction word.
- imem_rsp_ready  out  1  stage accepts response.
- redirect_valid  in  1  one-cycle pulse: next PC override.
- redirect_pc  in  WIDTH  redirect target.
- if_id_valid  out  1  IF_ID_message holds a valid instruction.
- if_id_ready  in  1  decode consumes IF_ID_message.
- IF_ID_message  out  2*WIDTH  {pc, inst}, pc in upper half.
- if_misalign  out  1  sticky flag: a redirect target had bits [1:0] nonzero.

Behaviour:
- Registers:
  - pc_q: next PC to fetch.
  - addr_q: address of the current request.
  - stale_q: the outstanding request must be discarded.
  - out_q: {pc, inst}.
  - state: 2 bits.
- Reset (rst low, asynchronous):
  - state=REQ, pc_q=addr_q=RESET_PC, stale_q=0, out_q=0, if_misalign=0.
  - All outputs then follow from these values: imem_req_valid=1, imem_addr=RESET_PC, if_id_valid=0, imem_rsp_ready=0.
- States:
  - REQ: imem_req_valid=1, imem_addr=addr_q.
    - On imem_req_ready, go to WAIT.
    - addr_q is held stable while imem_req_valid=1 and ready=0.
  - WAIT: imem_rsp_ready=1.
    - On imem_rsp_valid with stale_q=0: out_q<={addr_q, imem_rsp_data}, go to HOLD.
    - On imem_rsp_valid with stale_q=1: drop data, addr_q<=pc_q, stale_q<=0, go to REQ.
  - HOLD: if_id_valid=1, IF_ID_message=out_q, stable until handshake.
    - On if_id_ready: pc_q<=pc_q+4 and addr_q<=pc_q+4, go to REQ.
- Exactly one request outstanding; no request is issued in WAIT or HOLD.
- Latency: request accepted in cycle N and response in cycle M → if_id_valid high from cycle M+1. Best case is one instruction per 3 cycles.
- PC arithmetic is modulo 2^WIDTH; 32'hFFFF_FFFC + 4 wraps to 0.
- Redirect (redirect_valid=1), highest priority in every state:
  - REQ without accept in the same cycle: pc_q<=redirect_pc, stale_q<=1. The request continues unchanged; its response is dropped later.
  - REQ with accept in the same cycle: same as above, go to WAIT.
  - WAIT without response: pc_q<=redirect_pc, stale_q<=1.
  - WAIT with response in the same cycle: drop the response, addr_q<=pc_q<=redirect_pc, stale_q<=0, go to REQ.
  - HOLD, with or without if_id_ready: drop out_q, if_id_valid=0 next cycle, pc_q<=addr_q<=redirect_pc, go to REQ. Decode sees no handshake on a redirect cycle.
- Misaligned redirect: if redirect_pc[1:0]!=0, set if_misalign (cleared only by reset). Bits [1:0] are forced to 0 before use.
- A second redirect while stale_q=1 only updates pc_q.
- Reset asserted mid-transaction: all state is cleared immediately. The memory is required to abandon any outstanding response across reset.

Decomposition:
- Shared package holds:
  - state encoding: REQ=2'd0, WAIT=2'd1, HOLD=2'd2.
  - RESET_PC default.
  - IF_ID_WIDTH define (2*WIDTH), shared with the decode stage's message field widths.
- No sub-module needed. The whole stage is one FSM plus registers; the pc+4 adder is inline.

Test Plan:
- Reset, zero-wait memory returning 32'h00000013 at 8000_0000, if_id_ready=1 → if_id_valid high at cycle 3, IF_ID_message={32'h80000000, 32'h00000013}, next imem_addr=8000_0004.
- Decode holds if_id_ready=0 for 5 cycles → IF_ID_message stable, imem_req_valid=0, no new request issued.
- Redirect to 32'h80000100 while in WAIT, response arrives 2 cycles later → that response is dropped, next request addr=8000_0100, and the emitted pc is 8000_0100.
- Redirect coincident with response in WAIT, and redirect coincident with if_id_ready in HOLD → no instruction emitted, next imem_addr=redirect_pc.
- redirect_pc=32'h80000102 → if_misalign=1, fetch addr=8000_0100, flag persists until rst low.
- rst pulsed low while in WAIT → if_id_valid=0 immediately, imem_addr=8000_0000 after release.
